// File: rtl/audio_pll_lock_sequencer.sv
// Power-up / recovery sequencer for the audio PLL: pulses the PLL reset, waits for a
// stable lock, releases the audio domain, retries on timeout and re-sequences on lock loss.
module audio_pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          restart,
    output logic          pll_rst,
    output logic          audio_rst,
    output logic          ready,
    output logic          error,
    output logic          lock_lost,
    output logic [RW-1:0] retry_count,
    output logic [2:0]    state
);

    localparam int CNT_MAX_RL = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_RL > LOCK_STABLE) ? CNT_MAX_RL : LOCK_STABLE;
    localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t        st, st_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [RW-1:0] retry_next;
    logic          pll_rst_next, audio_rst_next, ready_next, error_next, lock_lost_next;
    logic          lock_p0, lock_p1;
    logic          lock_s;

    // pll_locked is asynchronous to refclk: two-flop synchroniser
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= pll_locked;
            lock_p1 <= lock_p0;
        end
    end

    assign lock_s = lock_p1;

    // State register; outputs are registered alongside so they move with the state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            st          <= RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            audio_rst   <= 1'b1;
            ready       <= 1'b0;
            error       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            st          <= st_next;
            cnt         <= cnt_next;
            retry_count <= retry_next;
            pll_rst     <= pll_rst_next;
            audio_rst   <= audio_rst_next;
            ready       <= ready_next;
            error       <= error_next;
            lock_lost   <= lock_lost_next;
        end
    end

    assign state = st;

    // Next-state logic; restart overrides every other transition
    always_comb begin
        st_next    = st;
        cnt_next   = cnt;
        retry_next = retry_count;
        if (restart) begin
            st_next    = RESET_PLL;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (st)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        st_next  = WAIT_LOCK;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        st_next  = STABLE;
                        cnt_next = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_count == RETRY_LIMIT) begin
                            st_next = FAIL;
                        end else begin
                            st_next    = RESET_PLL;
                            retry_next = retry_count + RW'(1);
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                STABLE: begin
                    // A lock glitch here restarts the wait without spending a retry
                    if (!lock_s) begin
                        st_next  = WAIT_LOCK;
                        cnt_next = '0;
                    end else if (cnt == STABLE_LAST) begin
                        st_next    = RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        st_next  = RESET_PLL;
                        cnt_next = '0;
                    end
                end
                FAIL: begin
                    st_next = FAIL;
                end
                default: begin
                    st_next    = RESET_PLL;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    // Output values implied by the state being entered on this edge
    always_comb begin
        pll_rst_next   = (st_next == RESET_PLL) || (st_next == FAIL);
        audio_rst_next = (st_next != RUN);
        ready_next     = (st_next == RUN);
        error_next     = (st_next == FAIL);
        lock_lost_next = (st == RUN) && !lock_s && !restart;
    end

endmodule

// File: doc/audio_pll_lock_sequencer.md
Name: audio_pll_lock_sequencer

Overview:
- Controls power-up and recovery of the audio PLL, which produces the 12.288 MHz codec clock from the 50 MHz reference.
- Drives the PLL reset and watches its lock output, synchronised into the reference clock domain.
- Requires lock to be held stable before releasing reset to downstream audio logic.
- Retries on lock timeout, flags a hard failure after a bounded number of attempts, and re-sequences automatically on loss of lock.

Parameters:
- RST_CYCLES, 16: cycles the PLL reset is held per attempt (≥2).
- LOCK_TIMEOUT, 50000: cycles to wait for lock per attempt (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive locked cycles required before RUN.
- MAX_RETRIES, 3: retries after the first attempt before FAIL.

Ports:
- refclk  in  1  reference clock (50 MHz), the only clock.
- rst  in  1  reset, asynchronous, active-high.
- pll_locked  in  1  PLL locked output, asynchronous to refclk.
- restart  in  1  synchronous single-cycle request to re-run the sequence.
- pll_rst  out  1  reset to the PLL, active-high.
- audio_rst  out  1  reset to audio-domain logic, active-high.
- ready  out  1  PLL locked and stable; audio path usable.
- error  out  1  lock failed after all retries.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- retry_count  out  clog2(MAX_RETRIES+1)  retries used in the current sequence.
- state  out  3  encoded state: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- Lock input: pll_locked passes through a 2-flop synchroniser (flops reset to 0) to form lock_s, a 2-cycle latency. Only lock_s is used internally.
- Outputs and state: all outputs are registered and change on the same edge as the state transition that implies them.
- Reset values on async rst: state=RESET_PLL, pll_rst=1, audio_rst=1, ready=0, error=0, lock_lost=0, retry_count=0, cycle counter=0.
  - rst asserted in any state forces these values immediately, without waiting for a clock edge.
- RESET_PLL:
  - Outputs: pll_rst=1, audio_rst=1, ready=0.
  - The counter runs 0..RST_CYCLES-1. On the edge where it equals RST_CYCLES-1, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - Outputs: pll_rst=0, audio_rst=1.
  - lock_s=1: go to STABLE, counter=0.
  - lock_s=0: counter increments.
  - Timeout (counter==LOCK_TIMEOUT-1 with lock_s=0): if retry_count==MAX_RETRIES, go to FAIL; else retry_count+1 and go to RESET_PLL.
- STABLE:
  - Outputs: pll_rst=0, audio_rst=1.
  - lock_s=0: go back to WAIT_LOCK with the counter cleared. This does not consume a retry; the timeout restarts.
  - Counter reaches LOCK_STABLE-1 with lock_s=1: go to RUN.
- RUN:
  - Outputs: ready=1, audio_rst=0, pll_rst=0. retry_count is cleared on entry.
  - lock_s=0: go to RESET_PLL, lock_lost=1 for exactly one cycle, ready=0, audio_rst=1.
- FAIL:
  - Outputs: error=1, pll_rst=1 (PLL held off), audio_rst=1, ready=0.
  - Exit only via restart or rst.
- restart:
  - Accepted in any state. Forces RESET_PLL, clears counter, retry_count and error.
  - Priority: rst > restart > every other transition, including a simultaneous lock loss or timeout. lock_lost is not pulsed when restart wins.
- Counter: sized clog2(max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)). It never wraps, because every terminal count causes a transition.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2; edges counted from the first refclk edge after rst deasserts):
- pll_locked tied 1 -> sequence completes on fixed edges:
  - pll_rst=1 through edge 3, falls at edge 4.
  - STABLE at edge 5.
  - ready=1 and audio_rst=0 at edge 13.
  - retry_count=0 throughout.
- pll_locked tied 0 -> exactly 3 pll_rst pulses of 4 cycles each, separated by 20-cycle waits. retry_count goes 0→1→2, then FAIL at edge 72 with error=1, pll_rst=1, state=4.
- pll_locked drops for 3 cycles midway through STABLE -> returns to WAIT_LOCK, no pll_rst pulse, retry_count unchanged. ready rises 8 cycles after lock_s re-asserts, plus one edge for WAIT_LOCK→STABLE.
- In RUN, pll_locked falls at cycle t:
  - At edge t+3: ready=0, audio_rst=1, pll_rst=1, and lock_lost=1 for one cycle.
  - Re-lock reaches RUN again after a further 4+1+8 edges.
- restart pulsed in FAIL -> next edge error=0, retry_count=0, state=0, and the full sequence reruns. restart coinciding with a RUN lock loss -> state=0 and lock_lost stays 0.
- rst asserted mid-RUN, between clock edges -> pll_rst=1, audio_rst=1, ready=0 and state=0 immediately. Release behaves identically to the first scenario.
